mvp_sequencer: RTL and testbench
================================

MVP_SEQUENCER -- requirements
Module: mvp_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 32, bit width of each signed fixed-point matrix element.
- TIMEOUT, 32, maximum cycles allowed per multiply issue/wait phase.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_in, in, 1, single clock; all logic on its rising edge.
- rst_in, in, 1, synchronous, active-high reset.
- start, in, 1, request to compute MVP = P*V*M.
- m_model, in, [3:0][3:0][WIDTH-1:0] signed, M matrix.
- m_view, in, [3:0][3:0][WIDTH-1:0] signed, V matrix.
- m_proj, in, [3:0][3:0][WIDTH-1:0] signed, P matrix.
- mvp_out, out, [3:0][3:0][WIDTH-1:0] signed, registered result.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle completion pulse.
- error, out, 1, last job timed out.
- mm_start, out, 1, start pulse to the 4x4 multiplier.
- mm_m1, out, [3:0][3:0][WIDTH-1:0] signed, left operand to the multiplier.
- mm_m2, out, [3:0][3:0][WIDTH-1:0] signed, right operand to the multiplier.
- mm_out, in, [3:0][3:0][WIDTH-1:0] signed, multiplier result.
- mm_busy, in, 1, multiplier busy.
- mm_done, in, 1, multiplier done pulse; mm_out is valid in that cycle.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, FINISH.
REQ-004 IDLE with start=1: latch M, V and P; clear error; set busy=1; go to ISSUE1. IDLE with start=0: stay.
REQ-005 start SHALL be ignored in every state except IDLE.
REQ-006 ISSUE1: drive mm_m1=V and mm_m2=M. If mm_busy=0, assert mm_start for exactly one cycle and go to WAIT1. If mm_busy=1, stall in ISSUE1 with mm_start=0.
REQ-007 WAIT1: when mm_done=1, capture mm_out into T (T = V*M) and go to ISSUE2. mm_busy SHALL be ignored in WAIT states.
REQ-008 ISSUE2: same as ISSUE1, except mm_m1=P and mm_m2=T. Then go to WAIT2.
REQ-009 WAIT2: when mm_done=1, capture mm_out into mvp_out and go to FINISH.
REQ-010 FINISH: done=1 for one cycle, busy=0, next state IDLE.
REQ-011 mm_m1/mm_m2 SHALL be registered and held stable from the ISSUE state through the end of the matching WAIT state.
REQ-012 mm_start SHALL never be high in two consecutive cycles, and SHALL never be high outside ISSUE1/ISSUE2.
REQ-013 An mm_done arriving in IDLE, FINISH or an ISSUE state SHALL be ignored.
REQ-014 A phase counter SHALL reset on entry to each ISSUE state and increment every cycle in the ISSUE and WAIT states. On reaching TIMEOUT:
- go to FINISH with done=1 and error=1;
- leave mvp_out unchanged.
error SHALL hold until the next accepted start.
REQ-015 The block SHALL perform no arithmetic; element values pass through bit-exact.
REQ-016 Latency with a multiplier start-to-done latency of L cycles and mm_busy=0:
- start accepted in cycle 0;
- mm_start in cycles 1 and L+2;
- done in cycle 2L+3.

Reset
REQ-017 While rst_in=1 at a clock edge, the block SHALL:
- set state=IDLE;
- set busy=0, done=0, error=0, mm_start=0;
- clear mvp_out, mm_m1, mm_m2, T, the latched inputs and the counter to 0.
REQ-018 Reset mid-job SHALL abort the job with no done pulse. After reset, a new start SHALL be accepted in the first cycle rst_in=0.

Verification (behavioural multiplier model, L=9, WIDTH=32, Q16.16)
REQ-019 M=V=P=identity (0x00010000 on the diagonal), start pulse:
- mm_start pulses in cycles 1 and 11;
- done in cycle 21;
- mvp_out=identity.
REQ-020 M=translate(1,2,3), V=scale(2), P=identity: mvp_out equals the exact product. Check [0][3]=0x00020000, [1][3]=0x00040000, [2][3]=0x00060000 and [3][3]=0x00010000.
REQ-021 start held high for the whole job:
- exactly two mm_start pulses;
- a new job begins in the cycle after done.
REQ-022 mm_busy=1 for 5 cycles at ISSUE1:
- mm_start is delayed by 5 cycles;
- done is at cycle 26.
REQ-023 Model never asserts mm_done, TIMEOUT=32:
- done=1 and error=1 in the cycle after the counter reaches 32;
- mvp_out keeps its previous value;
- the next start clears error.
REQ-024 rst_in pulsed during WAIT2:
- no done pulse;
- all outputs 0 the cycle after the reset edge;
- a following identity job completes normally.

Source files
------------

// File: rtl/mvp_sequencer.sv
// Sequences an external 4x4 multiplier twice to form MVP = P*(V*M).
// Operands and results are routed bit-exact; this block only handshakes and times out.
module mvp_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 32
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               start,
  input  logic signed [3:0][3:0][WIDTH-1:0]  m_model,
  input  logic signed [3:0][3:0][WIDTH-1:0]  m_view,
  input  logic signed [3:0][3:0][WIDTH-1:0]  m_proj,
  output logic signed [3:0][3:0][WIDTH-1:0]  mvp_out,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic                               mm_start,
  output logic signed [3:0][3:0][WIDTH-1:0]  mm_m1,
  output logic signed [3:0][3:0][WIDTH-1:0]  mm_m2,
  input  logic signed [3:0][3:0][WIDTH-1:0]  mm_out,
  input  logic                               mm_busy,
  input  logic                               mm_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE1 = 3'd1,
    S_WAIT1  = 3'd2,
    S_ISSUE2 = 3'd3,
    S_WAIT2  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t                            r_state;
  logic [CW-1:0]                     r_cnt;
  logic signed [3:0][3:0][WIDTH-1:0] r_p;
  logic signed [3:0][3:0][WIDTH-1:0] r_mvp;
  logic signed [3:0][3:0][WIDTH-1:0] r_m1;
  logic signed [3:0][3:0][WIDTH-1:0] r_m2;
  logic                              r_busy;
  logic                              r_done;
  logic                              r_error;
  logic                              w_issue;
  logic                              w_progress;
  logic                              w_timeout;

  // Phase decode: mm_start follows mm_busy in the same cycle so a free multiplier is hit immediately.
  always_comb begin
    w_issue    = 1'b0;
    w_progress = 1'b0;
    case (r_state)
      S_ISSUE1, S_ISSUE2: begin
        w_issue    = 1'b1;
        w_progress = ~mm_busy;
      end
      S_WAIT1, S_WAIT2: begin
        w_issue    = 1'b0;
        w_progress = mm_done;
      end
      default: begin
        w_issue    = 1'b0;
        w_progress = 1'b0;
      end
    endcase
    w_timeout = (r_cnt >= CW'(TIMEOUT - 1));
  end

  // Sequencer FSM; mm_m2 doubles as the T = V*M holding register during phase 2.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_mvp   <= '0;
      r_m1    <= '0;
      r_m2    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_p     <= m_proj;
            r_m1    <= m_view;
            r_m2    <= m_model;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_ISSUE1;
          end
        end
        S_ISSUE1, S_WAIT1, S_ISSUE2, S_WAIT2: begin
          // Progress wins over a timeout landing in the same cycle.
          if (w_progress) begin
            case (r_state)
              S_ISSUE1: begin
                r_cnt   <= r_cnt + CW'(1);
                r_state <= S_WAIT1;
              end
              S_ISSUE2: begin
                r_cnt   <= r_cnt + CW'(1);
                r_state <= S_WAIT2;
              end
              S_WAIT1: begin
                r_m1    <= r_p;
                r_m2    <= mm_out;
                r_cnt   <= '0;
                r_state <= S_ISSUE2;
              end
              S_WAIT2: begin
                r_mvp   <= mm_out;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_FINISH;
              end
              default: r_state <= S_IDLE;
            endcase
          end else if (w_timeout) begin
            r_done  <= 1'b1;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FINISH;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mvp_out  = r_mvp;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign mm_m1    = r_m1;
  assign mm_m2    = r_m2;
  assign mm_start = w_issue & ~mm_busy;

endmodule

// File: tb/tb_mvp_sequencer.sv
// Randomized bench for mvp_sequencer: a Q16.16 multiplier model answers the handshake,
// and expectations come from P*(V*M) plus closed-form cycle timing.
module tb_mvp_sequencer;

  localparam int W  = 32;
  localparam int TO = 32;
  typedef logic signed [3:0][3:0][W-1:0] mat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in, start, mm_start, mm_busy, mm_done, busy, done, error;
  mat_t m_model, m_view, m_proj, mvp_out, mm_m1, mm_m2, mm_out;
  mat_t last_mvp;
  int   n_vec = 0;
  int   n_err = 0;

  mvp_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_in(clk), .rst_in(rst_in), .start(start),
    .m_model(m_model), .m_view(m_view), .m_proj(m_proj),
    .mvp_out(mvp_out), .busy(busy), .done(done), .error(error),
    .mm_start(mm_start), .mm_m1(mm_m1), .mm_m2(mm_m2),
    .mm_out(mm_out), .mm_busy(mm_busy), .mm_done(mm_done)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Q16.16 matrix product, truncated to W bits
  function automatic mat_t qmul(input mat_t a, input mat_t b);
    mat_t   r;
    longint acc;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 64'sd0;
        for (int k = 0; k < 4; k++)
          acc += longint'($signed(a[i][k])) * longint'($signed(b[k][j]));
        r[i][j] = W'(acc >>> 16);
      end
    end
    return r;
  endfunction

  function automatic mat_t rnd_mat();
    mat_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i][j] = $urandom;
    return r;
  endfunction

  function automatic mat_t ident();
    mat_t r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i][i] = 32'h0001_0000;
    return r;
  endfunction

  // nodone: 0 = normal, 1 = no mm_done in phase 1, 2 = no mm_done in phase 2
  task automatic run_job(input mat_t M, input mat_t V, input mat_t P, input int L,
                         input int s1, input int s2, input int nodone, input bit spur,
                         input bit hold, input int rst_at, output int done_at);
    int   ms1, d1, ms2, d2, exp_done, last;
    mat_t vm, exp_mvp, pend;
    bit   exp_err, exp_ms, real_done;
    ms1      = 1 + s1;
    d1       = ms1 + L;
    ms2      = d1 + 1 + s2;
    d2       = ms2 + L;
    vm       = qmul(V, M);
    exp_done = (nodone == 1) ? 1 + TO : (nodone == 2) ? d1 + 1 + TO : d2 + 1;
    exp_mvp  = (nodone == 0) ? qmul(P, vm) : last_mvp;
    exp_err  = (nodone != 0);
    last     = (rst_at > 0) ? rst_at : exp_done;
    done_at  = -1;
    pend     = '0;
    @(negedge clk);
    start = 1'b1; m_model = M; m_view = V; m_proj = P;
    mm_busy = 1'b0; mm_done = 1'b0; mm_out = rnd_mat();
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start   = hold;
      m_model = rnd_mat(); m_view = rnd_mat(); m_proj = rnd_mat();
      mm_busy   = (c <= s1) || (nodone != 1 && c > d1 && c <= d1 + s2);
      real_done = (c == d1 && nodone != 1) || (c == d2 && nodone == 0);
      mm_done   = real_done || (spur && (c == 1 || (nodone != 1 && c == d1 + 1)));
      mm_out    = real_done ? pend : rnd_mat();
      rst_in    = (c == rst_at);
      #1;
      exp_ms = (c == ms1) || (nodone != 1 && c == ms2);
      chk("mm_start", 512'(mm_start), 512'(exp_ms));
      if (mm_start) pend = qmul(mm_m1, mm_m2);
      if (c == ms1 || c == d1) begin
        chk("op1_m1", mm_m1, V);
        chk("op1_m2", mm_m2, M);
      end
      if (nodone != 1 && (c == ms2 || c == d2)) begin
        chk("op2_m1", mm_m1, P);
        chk("op2_m2", mm_m2, vm);
      end
      chk("busy", 512'(busy), 512'(c < exp_done));
      chk("done", 512'(done), 512'(c == exp_done));
      chk("error", 512'(error), 512'(c == exp_done && exp_err));
      if (done && done_at < 0) done_at = c;
      if (c == exp_done) chk("mvp_out", mvp_out, exp_mvp);
    end
    @(negedge clk);
    mm_busy = 1'b0; mm_done = 1'b0;
    if (rst_at > 0) begin
      rst_in = 1'b0;
      #1;
      chk("rst_mvp", mvp_out, '0);
      chk("rst_m1", mm_m1, '0);
      chk("rst_m2", mm_m2, '0);
      chk("rst_flags", 512'({busy, done, error, mm_start}), 512'(4'b0000));
      last_mvp = '0;
    end else begin
      #1;
      chk("done_one_cycle", 512'(done), 512'(1'b0));
      chk("busy_idle", 512'(busy), 512'(1'b0));
      chk("error_hold", 512'(error), 512'(exp_err));
      if (nodone == 0) last_mvp = exp_mvp;
      if (hold) begin
        @(negedge clk); #1;
        chk("restart_busy", 512'(busy), 512'(1'b1));
        chk("restart_mm_start", 512'(mm_start), 512'(1'b1));
        start = 1'b0; rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        last_mvp = '0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mat_t id, tr, sc, prev, x, y, z;
    int   dat, nd;
    rst_in = 1'b1; start = 1'b0; mm_busy = 1'b0; mm_done = 1'b0;
    mm_out = '0; m_model = '0; m_view = '0; m_proj = '0; last_mvp = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_mvp", mvp_out, '0);
    chk("reset_m1", mm_m1, '0);
    chk("reset_m2", mm_m2, '0);
    chk("reset_flags", 512'({busy, done, error, mm_start}), 512'(4'b0000));
    rst_in = 1'b0;

    id = ident();
    run_job(id, id, id, 9, 0, 0, 0, 1'b0, 1'b0, 0, dat);
    chk("id_done_cycle", 512'(dat), 512'(21));
    chk("id_mvp", mvp_out, id);

    tr = id;
    tr[0][3] = 32'h0001_0000; tr[1][3] = 32'h0002_0000; tr[2][3] = 32'h0003_0000;
    sc = id;
    sc[0][0] = 32'h0002_0000; sc[1][1] = 32'h0002_0000; sc[2][2] = 32'h0002_0000;
    run_job(tr, sc, id, 9, 0, 0, 0, 1'b0, 1'b0, 0, dat);
    chk("ts_03", 512'(mvp_out[0][3]), 512'(32'h0002_0000));
    chk("ts_13", 512'(mvp_out[1][3]), 512'(32'h0004_0000));
    chk("ts_23", 512'(mvp_out[2][3]), 512'(32'h0006_0000));
    chk("ts_33", 512'(mvp_out[3][3]), 512'(32'h0001_0000));

    run_job(id, id, id, 9, 5, 0, 0, 1'b1, 1'b0, 0, dat);
    chk("stall_done_cycle", 512'(dat), 512'(26));

    prev = mvp_out;
    run_job(rnd_mat(), rnd_mat(), rnd_mat(), 9, 0, 0, 1, 1'b0, 1'b0, 0, dat);
    chk("to1_done_cycle", 512'(dat), 512'(1 + TO));
    chk("to1_mvp_kept", mvp_out, prev);

    run_job(rnd_mat(), rnd_mat(), rnd_mat(), 4, 2, 1, 0, 1'b1, 1'b0, 0, dat);
    chk("err_cleared", 512'(error), 512'(1'b0));

    prev = mvp_out;
    run_job(rnd_mat(), rnd_mat(), rnd_mat(), 6, 1, 3, 2, 1'b1, 1'b0, 0, dat);
    chk("to2_done_cycle", 512'(dat), 512'(1 + 1 + 6 + 1 + TO));
    chk("to2_mvp_kept", mvp_out, prev);

    run_job(id, id, id, 4, 1, 1, 0, 1'b0, 1'b1, 0, dat);
    chk("hold_done_cycle", 512'(dat), 512'(1 + 1 + 4 + 1 + 1 + 4 + 1));

    run_job(rnd_mat(), rnd_mat(), rnd_mat(), 9, 0, 0, 0, 1'b0, 1'b0, 13, dat);
    chk("rst_no_done", 512'(dat), 512'(-1));
    run_job(id, id, id, 9, 0, 0, 0, 1'b0, 1'b0, 0, dat);
    chk("post_rst_done_cycle", 512'(dat), 512'(21));
    chk("post_rst_mvp", mvp_out, id);

    for (int n = 0; n < 20; n++) begin
      x  = rnd_mat(); y = rnd_mat(); z = rnd_mat();
      nd = ($urandom_range(4, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
      run_job(x, y, z, int'($urandom_range(12, 1)), int'($urandom_range(5, 0)),
              int'($urandom_range(5, 0)), nd, 1'($urandom_range(1, 0)), 1'b0, 0, dat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
